// File: rtl/melody_sequencer.sv
// Melody sequencer: plays a 16-step pattern of key masks onto the synth keys input.
// Each step is a NOTE phase followed by a silent GAP so repeated notes re-trigger.
module melody_sequencer #(
    parameter int unsigned BEAT_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       loop_i,
    input  logic       wr_en_i,
    input  logic [3:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    output logic [3:0] keys_o,
    output logic       busy_o,
    output logic [3:0] step_o,
    output logic       done_o
);

    // Wide enough that 15 * BEAT_CYCLES never wraps.
    localparam int unsigned CntW = 4 + $clog2(BEAT_CYCLES + 1);
    localparam logic [CntW-1:0] BeatC   = CntW'(BEAT_CYCLES);
    localparam logic [CntW-1:0] GapC    = CntW'(GAP_CYCLES);
    localparam logic [CntW-1:0] GapLast = GapC - CntW'(1);

    typedef enum logic [1:0] {StIdle, StNote, StGap} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        step_q, step_d;
    logic [3:0]        dur_q, dur_d;
    logic [3:0]        mask_q, mask_d;
    logic              done_q, done_d;
    logic [7:0]        ram_q [16];

    logic [CntW-1:0]   note_last;
    logic [3:0]        next_step;
    logic [7:0]        next_entry;
    logic [7:0]        first_entry;
    logic              end_of_pattern;
    logic              write_en;
    logic              step_end;

    assign note_last      = CntW'(dur_q) * BeatC - GapC - CntW'(1);
    assign next_step      = step_q + 4'd1;
    assign next_entry     = ram_q[next_step];
    assign first_entry    = ram_q[4'd0];
    assign end_of_pattern = (step_q == 4'd15) || (next_entry[7:4] == 4'd0);
    assign write_en       = wr_en_i && (state_q == StIdle) && !start_i;

    // Outputs decode from state so reset silences keys without waiting for a clock.
    assign keys_o = (state_q == StNote) ? mask_q : 4'd0;
    assign busy_o = (state_q != StIdle);
    assign step_o = step_q;
    assign done_o = done_q;

    // Pattern RAM: cleared on reset, writable only when idle and not starting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) ram_q[i] <= 8'h00;
        end else if (write_en) begin
            ram_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            step_q  <= 4'd0;
            dur_q   <= 4'd0;
            mask_q  <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            dur_q   <= dur_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: phase timing, step advance, end-of-pattern, stop override.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        dur_d    = dur_q;
        mask_d   = mask_q;
        done_d   = 1'b0;
        step_end = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (first_entry[7:4] == 4'd0) begin
                        done_d = 1'b1;
                    end else begin
                        step_d  = 4'd0;
                        dur_d   = first_entry[7:4];
                        mask_d  = first_entry[3:0];
                        cnt_d   = '0;
                        state_d = StNote;
                    end
                end
            end
            StNote: begin
                if (cnt_q == note_last) begin
                    cnt_d = '0;
                    if (GapC == '0) step_end = 1'b1;
                    else            state_d  = StGap;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d    = '0;
                    step_end = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (step_end) begin
            if (end_of_pattern) begin
                if (loop_i) begin
                    step_d  = 4'd0;
                    dur_d   = first_entry[7:4];
                    mask_d  = first_entry[3:0];
                    state_d = StNote;
                end else begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end else begin
                step_d  = next_step;
                dur_d   = next_entry[7:4];
                mask_d  = next_entry[3:0];
                state_d = StNote;
            end
        end

        if (stop_i) begin
            state_d = StIdle;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
    end

endmodule
